log_base: RTL

LOG_BASE -- requirements
Module: log_base

---
 rtl/log_base.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/log_base.sv
// log_base: BF16 log_a(b) of two signed 16-bit integers via CORDIC ln + divide.
// Ports: clk, rst, start, a, b -> result (BF16), error, done.
module log_base #(
  parameter int ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        error,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE,
    VALIDATE,
    PREP_A,
    LN_A,
    PREP_B,
    LN_B,
    DIV,
    CONV_CLZ,
    CONV_PACK,
    DONE
  } state_t;

  localparam logic [31:0] LN2  = 32'h0000_B172;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam int          NSTP = ITERATIONS + 2;
  localparam logic [4:0]  LAST = 5'(NSTP - 1);
  // Roughly 1/8 ulp added before truncation so that
  // quotients a few LSBs under an exact value pack
  // to that value instead of the ulp below.
  localparam logic [32:0] BIAS = 33'h0_0020_0000;

  function automatic logic [5:0] clz32(
    input logic [31:0] v
  );
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  // Step k -> shift i, with i=4 and i=13 repeated.
  function automatic logic [4:0] step_shift(
    input logic [4:0] k
  );
    logic [4:0] s;
    s = k + 5'd1;
    if (k >= 5'd4)  s = s - 5'd1;
    if (k >= 5'd14) s = s - 5'd1;
    return s;
  endfunction

  function automatic logic [31:0] atanh_q(
    input logic [4:0] i
  );
    logic [31:0] v;
    case (i)
      5'd1:    v = 32'd35999;
      5'd2:    v = 32'd16739;
      5'd3:    v = 32'd8235;
      5'd4:    v = 32'd4101;
      5'd5:    v = 32'd2049;
      default: v = ONE >> i;
    endcase
    return v;
  endfunction

  state_t             state;
  logic [15:0]        a_r;
  logic [15:0]        b_r;
  logic signed [31:0] x;
  logic signed [31:0] y;
  logic signed [31:0] z;
  logic [4:0]         step;
  logic [4:0]         e_r;
  logic [31:0]        ln_a;
  logic [31:0]        ln_b;
  logic [47:0]        dvd;
  logic [31:0]        rem;
  logic [31:0]        quo;
  logic [5:0]         cnt;
  logic [4:0]         shamt;

  logic [15:0]        op;
  logic [31:0]        op_q;
  logic [5:0]         op_n;
  logic [31:0]        op_norm;
  logic [31:0]        mant;
  logic [4:0]         sh;
  logic [31:0]        ang;
  logic signed [31:0] xs;
  logic signed [31:0] ys;
  logic signed [31:0] x_n;
  logic signed [31:0] y_n;
  logic signed [31:0] z_n;
  logic [31:0]        ln_n;
  logic [32:0]        rem_sh;
  logic [32:0]        diff;
  logic               ge;
  logic [31:0]        rem_n;
  logic [5:0]         q_n;
  logic [31:0]        norm;
  logic [32:0]        sum;
  logic [7:0]         exp8;

  always_comb begin
    op      = (state == PREP_B) ? b_r : a_r;
    op_q    = {op, 16'h0000};
    op_n    = clz32(op_q);
    op_norm = op_q << op_n[4:0];
    // Leading one lands on bit 16: mantissa in [1,2).
    mant    = {15'd0, op_norm[31:15]};
  end

  always_comb begin
    sh  = step_shift(step);
    ang = atanh_q(sh);
    xs  = x >>> sh;
    ys  = y >>> sh;
    if (!y[31]) begin
      x_n = x - ys;
      y_n = y - xs;
      z_n = z + $signed(ang);
    end else begin
      x_n = x + ys;
      y_n = y + xs;
      z_n = z - $signed(ang);
    end
    ln_n = {z_n[30:0], 1'b0}
         + (32'(e_r) * LN2);
  end

  always_comb begin
    rem_sh = {rem, dvd[47]};
    diff   = rem_sh - {1'b0, ln_a};
    ge     = !diff[32];
    rem_n  = ge ? diff[31:0] : rem_sh[31:0];
  end

  always_comb begin
    q_n  = clz32(quo);
    norm = quo << shamt;
    sum  = {1'b0, norm} + BIAS;
    // A carry out means the mantissa rolled over.
    exp8 = 8'd142 - {3'd0, shamt}
         + {7'd0, sum[32]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= 16'h0000;
      error  <= 1'b0;
      done   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      step   <= '0;
      e_r    <= '0;
      ln_a   <= '0;
      ln_b   <= '0;
      dvd    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      shamt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            state <= VALIDATE;
          end
        end
        VALIDATE: begin
          if ($signed(a_r) <= 16'sd1 ||
              $signed(b_r) <= 16'sd0) begin
            error  <= 1'b1;
            result <= 16'h0000;
            state  <= DONE;
          end else if (b_r == 16'd1) begin
            error  <= 1'b0;
            result <= 16'h0000;
            state  <= DONE;
          end else begin
            state <= PREP_A;
          end
        end
        PREP_A, PREP_B: begin
          x     <= $signed(mant + ONE);
          y     <= $signed(mant - ONE);
          z     <= '0;
          step  <= '0;
          e_r   <= 5'(6'd15 - op_n);
          state <= (state == PREP_A) ?
                   LN_A : LN_B;
        end
        LN_A, LN_B: begin
          x    <= x_n;
          y    <= y_n;
          z    <= z_n;
          step <= step + 5'd1;
          if (step == LAST) begin
            if (state == LN_A) begin
              ln_a  <= ln_n;
              state <= PREP_B;
            end else begin
              ln_b  <= ln_n;
              dvd   <= {ln_n, 16'h0000};
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          dvd <= {dvd[46:0], 1'b0};
          rem <= rem_n;
          quo <= {quo[30:0], ge};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd47) state <= CONV_CLZ;
        end
        CONV_CLZ: begin
          if (quo == 32'd0) begin
            result <= 16'h0000;
            state  <= DONE;
          end else begin
            shamt <= q_n[4:0];
            state <= CONV_PACK;
          end
        end
        CONV_PACK: begin
          result <= {1'b0, exp8, sum[30:24]};
          state  <= DONE;
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
